// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants and types.
//   SAMPLE_W  - bits per complex sample {re float32 [63:32], im float32 [31:0]}
//   N_SAMPLES - complex samples per frame
//   LOG2N     - address width of a frame slot
//   cplx_t    - packed complex sample
//   TW_*      - trivial twiddle factors (1, -j, -1, +j) as float32 pairs
//   rd_state_t - frame loader read-side state
//   bit_reverse() - slot index for decimation-in-time ordering
package fft_pkg;

  localparam int unsigned SAMPLE_W  = 64;
  localparam int unsigned N_SAMPLES = 32;
  localparam int unsigned LOG2N     = 5;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx_t;

  localparam cplx_t TW_ONE     = '{re: 32'h3F80_0000, im: 32'h0000_0000};
  localparam cplx_t TW_NEG_J   = '{re: 32'h0000_0000, im: 32'hBF80_0000};
  localparam cplx_t TW_NEG_ONE = '{re: 32'hBF80_0000, im: 32'h0000_0000};
  localparam cplx_t TW_POS_J   = '{re: 32'h0000_0000, im: 32'h3F80_0000};

  typedef enum logic {
    R_EMPTY,
    R_FULL
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    for (int b = 0; b < LOG2N; b++) begin
      rev[b] = idx[LOG2N-1-b];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one frame of N_SAMPLES x SAMPLE_W registers, single write port,
// whole frame visible on the read side.
//   clk, reset (async, active-low; clears every slot)
//   we, waddr, wdata - write one slot
//   rdata            - full frame, slot k at [k*SAMPLE_W +: SAMPLE_W]
module fft_frame_bank #(
  parameter int unsigned N_SAMPLES = fft_pkg::N_SAMPLES,
  parameter int unsigned SAMPLE_W  = fft_pkg::SAMPLE_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [fft_pkg::LOG2N-1:0]     waddr,
  input  logic [SAMPLE_W-1:0]           wdata,
  output logic [N_SAMPLES*SAMPLE_W-1:0] rdata
);

  import fft_pkg::*;

  for (genvar k = 0; k < N_SAMPLES; k++) begin : g_slot
    logic [SAMPLE_W-1:0] slot_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot_q <= '0;
      end else if (we && (waddr == LOG2N'(k))) begin
        slot_q <= wdata;
      end
    end

    assign rdata[k*SAMPLE_W +: SAMPLE_W] = slot_q;
  end

endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: collects a stream of complex samples into ping-pong frame banks and
// presents complete frames to the butterfly stage.
//   clk, reset        - clock, async active-low reset
//   in_valid/in_ready - sample handshake; in_data sample, in_last frame marker
//   frame_valid       - complete frame presented on frame_data
//   frame_ack         - one-cycle pulse: stage is done with the presented frame
//   frame_err         - one-cycle pulse on in_last framing mismatch
// Build option: define FFT_LOADER_BITREV_EN to store sample i at slot bit_reverse(i)
// (decimation-in-time order); otherwise sample i goes to slot i.
module fft_frame_loader #(
  parameter int unsigned N_SAMPLES = fft_pkg::N_SAMPLES,
  parameter int unsigned SAMPLE_W  = fft_pkg::SAMPLE_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_W-1:0]           in_data,
  input  logic                          in_last,
  output logic                          frame_valid,
  input  logic                          frame_ack,
  output logic [N_SAMPLES*SAMPLE_W-1:0] frame_data,
  output logic                          frame_err
);

  import fft_pkg::*;

  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N_SAMPLES - 1);

  rd_state_t        rd_state_q, rd_state_d;
  logic             wr_sel_q, wr_sel_d;    // index of the bank currently being written
  logic             pending_q, pending_d;  // write bank holds a frame waiting for a swap
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             accept;
  logic             at_last;
  logic             complete;
  logic [LOG2N-1:0] waddr;
  logic [N_SAMPLES*SAMPLE_W-1:0] rdata0, rdata1;

  assign in_ready    = ~pending_q;
  assign accept      = in_valid & in_ready;
  assign at_last     = (wr_cnt_q == LastIdx);
  assign complete    = accept & at_last;
  assign frame_valid = (rd_state_q == R_FULL);
  assign frame_err   = frame_err_q;
  assign frame_data  = wr_sel_q ? rdata0 : rdata1;

`ifdef FFT_LOADER_BITREV_EN
  assign waddr = bit_reverse(wr_cnt_q);
`else
  assign waddr = wr_cnt_q;
`endif

  always_comb begin
    rd_state_d  = rd_state_q;
    wr_sel_d    = wr_sel_q;
    pending_d   = pending_q;
    wr_cnt_d    = wr_cnt_q;
    frame_err_d = 1'b0;

    // The last slot always closes the frame; in_last only flags a mismatch there.
    if (accept) begin
      if (at_last) begin
        wr_cnt_d    = '0;
        frame_err_d = ~in_last;
      end else if (in_last) begin
        wr_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    case (rd_state_q)
      R_EMPTY: begin
        if (complete) begin
          rd_state_d = R_FULL;
          wr_sel_d   = ~wr_sel_q;
        end
      end
      R_FULL: begin
        if (frame_ack) begin
          // A pending frame and a frame completing this cycle are mutually exclusive,
          // since in_ready is low while pending.
          if (pending_q || complete) begin
            wr_sel_d  = ~wr_sel_q;
            pending_d = 1'b0;
          end else begin
            rd_state_d = R_EMPTY;
          end
        end else if (complete) begin
          pending_d = 1'b1;
        end
      end
      default: rd_state_d = R_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q  <= R_EMPTY;
      wr_sel_q    <= 1'b0;
      pending_q   <= 1'b0;
      wr_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_sel_q    <= wr_sel_d;
      pending_q   <= pending_d;
      wr_cnt_q    <= wr_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  fft_frame_bank #(
    .N_SAMPLES (N_SAMPLES),
    .SAMPLE_W  (SAMPLE_W)
  ) u_bank0 (
    .clk   (clk),
    .reset (reset),
    .we    (accept & ~wr_sel_q),
    .waddr (waddr),
    .wdata (in_data),
    .rdata (rdata0)
  );

  fft_frame_bank #(
    .N_SAMPLES (N_SAMPLES),
    .SAMPLE_W  (SAMPLE_W)
  ) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .we    (accept & wr_sel_q),
    .waddr (waddr),
    .wdata (in_data),
    .rdata (rdata1)
  );

endmodule
